// File: rtl/char_rx.sv
// rtl/char_rx.sv - 8N1 serial character receiver feeding the expression recognizer.
// Emits one char_valid pulse per good frame and one frame_err pulse per bad stop bit.
module char_rx #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rxd,
  output logic [7:0] char,
  output logic       char_valid,
  output logic       frame_err,
  output logic       busy
);

  localparam int HALF_BIT = CLKS_PER_BIT / 2;
  localparam int CW       = $clog2(CLKS_PER_BIT);

  // Counter runs from 0 at the cycle after each reference point, so the
  // sample lands when it reaches (interval - 1).
  localparam logic [CW-1:0] HALF_LAST = CW'(HALF_BIT - 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    STOP      = 3'd3,
    WAIT_HIGH = 3'd4
  } state_e;

  state_e          state_q, state_d;
  logic            sync1_q, sync1_d;
  logic            rx_s_q, rx_s_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [3:0]      bit_idx_q, bit_idx_d;
  logic [7:0]      shift_q, shift_d;
  logic [7:0]      char_q, char_d;
  logic            char_valid_q, char_valid_d;
  logic            frame_err_q, frame_err_d;
  logic            busy_q, busy_d;

  always_comb begin
    sync1_d      = rxd;
    rx_s_d       = sync1_q;
    state_d      = state_q;
    cnt_d        = cnt_q;
    bit_idx_d    = bit_idx_q;
    shift_d      = shift_q;
    char_d       = char_q;
    char_valid_d = 1'b0;
    frame_err_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (!rx_s_q) begin
          state_d = START;
          cnt_d   = '0;
        end
      end
      START: begin
        if (cnt_q == HALF_LAST) begin
          cnt_d = '0;
          if (!rx_s_q) begin
            state_d   = DATA;
            bit_idx_d = 4'd0;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DATA: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d     = '0;
          shift_d   = {rx_s_q, shift_q[7:1]};
          bit_idx_d = bit_idx_q + 4'd1;
          if (bit_idx_q == 4'd7) begin
            state_d = STOP;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      STOP: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d = '0;
          if (rx_s_q) begin
            char_d       = shift_q;
            char_valid_d = 1'b1;
            state_d      = IDLE;
          end else begin
            frame_err_d = 1'b1;
            state_d     = WAIT_HIGH;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      WAIT_HIGH: begin
        // A break or stuck-low line must go high before another frame is accepted.
        if (rx_s_q) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q      <= 1'b1;
      rx_s_q       <= 1'b1;
      state_q      <= IDLE;
      cnt_q        <= '0;
      bit_idx_q    <= 4'd0;
      shift_q      <= 8'h00;
      char_q       <= 8'h00;
      char_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      sync1_q      <= sync1_d;
      rx_s_q       <= rx_s_d;
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      bit_idx_q    <= bit_idx_d;
      shift_q      <= shift_d;
      char_q       <= char_d;
      char_valid_q <= char_valid_d;
      frame_err_q  <= frame_err_d;
      busy_q       <= busy_d;
    end
  end

  assign char       = char_q;
  assign char_valid = char_valid_q;
  assign frame_err  = frame_err_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_char_rx.sv
// tb/tb_char_rx.sv - directed self-checking bench for char_rx at CLKS_PER_BIT=4.
module tb_char_rx;

  localparam int C = 4;
  // Pulse appears at t=HALF_BIT+9*C+1 = 39; t=0 is two sync stages after rxd falls,
  // and the monitor counts from the first negedge after the drive, giving 39+2+1.
  localparam int PULSE_OFS = 42;

  logic       clk = 1'b0;
  logic       reset;
  logic       rxd;
  logic [7:0] char;
  logic       char_valid;
  logic       frame_err;
  logic       busy;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int both_cnt = 0;
  int busy_cnt = 0;
  int cv_cyc[$];
  logic [7:0] cv_char[$];
  int fe_cyc[$];
  int start_cyc;

  always #5 clk = ~clk;

  char_rx #(.CLKS_PER_BIT(C)) dut (
    .clk        (clk),
    .reset      (reset),
    .rxd        (rxd),
    .char       (char),
    .char_valid (char_valid),
    .frame_err  (frame_err),
    .busy       (busy)
  );

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (char_valid) begin
      cv_cyc.push_back(cyc + 1);
      cv_char.push_back(char);
    end
    if (frame_err) fe_cyc.push_back(cyc + 1);
    if (char_valid && frame_err) both_cnt <= both_cnt + 1;
    if (busy) busy_cnt <= busy_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_bit(input logic b);
    rxd = b;
    tick(C);
  endtask

  task automatic send_frame(input logic [7:0] c, input logic stop_b);
    rxd = 1'b0;
    start_cyc = cyc;
    tick(C);
    for (int i = 0; i < 8; i++) send_bit(c[i]);
    send_bit(stop_b);
  endtask

  logic [7:0] msg [5];
  int cvb, feb, bb, s;

  initial begin
    msg = '{8'h31, 8'h2B, 8'h32, 8'h3D, 8'h33};
    reset = 1'b0;
    rxd   = 1'b1;
    tick(3);
    check("rst_char", char, 8'h00);
    check("rst_valid", char_valid, 1'b0);
    check("rst_ferr", frame_err, 1'b0);
    check("rst_busy", busy, 1'b0);
    reset = 1'b1;
    tick(2);

    // Idle line
    bb = busy_cnt; cvb = cv_cyc.size(); feb = fe_cyc.size();
    tick(1000);
    check("idle_busy", busy_cnt - bb, 0);
    check("idle_valid", cv_cyc.size() - cvb, 0);
    check("idle_ferr", fe_cyc.size() - feb, 0);

    // Single frame 0x37
    cvb = cv_cyc.size(); feb = fe_cyc.size();
    send_frame(8'h37, 1'b1);
    s = start_cyc;
    tick(10);
    check("c37_count", cv_cyc.size() - cvb, 1);
    check("c37_char", char, 8'h37);
    check("c37_time", (cv_cyc.size() > cvb) ? cv_cyc[cvb] - s : -1, PULSE_OFS);
    check("c37_ferr", fe_cyc.size() - feb, 0);

    // Back-to-back "1+2=3"
    cvb = cv_cyc.size(); feb = fe_cyc.size(); s = 0;
    for (int i = 0; i < 5; i++) begin
      send_frame(msg[i], 1'b1);
      if (i == 0) s = start_cyc;
    end
    tick(10);
    check("b2b_count", cv_cyc.size() - cvb, 5);
    check("b2b_first", (cv_cyc.size() > cvb) ? cv_cyc[cvb] - s : -1, PULSE_OFS);
    for (int i = 0; i < 5; i++) begin
      check($sformatf("b2b_char%0d", i),
            (cv_char.size() > cvb + i) ? {24'h0, cv_char[cvb + i]} : 32'hDEAD, {24'h0, msg[i]});
      if (i > 0)
        check($sformatf("b2b_gap%0d", i),
              (cv_cyc.size() > cvb + i) ? cv_cyc[cvb + i] - cv_cyc[cvb + i - 1] : -1, 40);
    end
    check("b2b_ferr", fe_cyc.size() - feb, 0);

    // One-cycle glitch
    cvb = cv_cyc.size(); feb = fe_cyc.size();
    rxd = 1'b0;
    tick(1);
    rxd = 1'b1;
    tick(20);
    check("gl_valid", cv_cyc.size() - cvb, 0);
    check("gl_ferr", fe_cyc.size() - feb, 0);
    check("gl_busy", busy, 1'b0);
    check("gl_char", char, 8'h33);

    // Framing error then stuck-low line
    cvb = cv_cyc.size(); feb = fe_cyc.size();
    send_frame(8'h41, 1'b0);
    s = start_cyc;
    tick(100);
    check("fe_count", fe_cyc.size() - feb, 1);
    check("fe_time", (fe_cyc.size() > feb) ? fe_cyc[feb] - s : -1, PULSE_OFS);
    check("fe_valid", cv_cyc.size() - cvb, 0);
    check("fe_char", char, 8'h33);
    check("fe_busy_low", busy, 1'b1);
    rxd = 1'b1;
    tick(6);
    check("fe_busy_rel", busy, 1'b0);

    // Reset during data bit 4 of 0x55
    cvb = cv_cyc.size(); feb = fe_cyc.size();
    rxd = 1'b0;
    tick(C);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    rxd = 1'b1;
    tick(2);
    check("mr_busy_pre", busy, 1'b1);
    reset = 1'b0;
    #1;
    check("mr_char_async", char, 8'h00);
    check("mr_busy_async", busy, 1'b0);
    tick(3);
    reset = 1'b1;
    tick(10);
    check("mr_char_rel", char, 8'h00);
    check("mr_valid", cv_cyc.size() - cvb, 0);
    check("mr_ferr", fe_cyc.size() - feb, 0);
    send_frame(8'h2D, 1'b1);
    tick(10);
    check("mr_count", cv_cyc.size() - cvb, 1);
    check("mr_char", char, 8'h2D);

    check("no_overlap", both_cnt, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/char_rx.md
Name: char_rx

Overview:
- Serial character receiver sitting directly upstream of the expression-recognizer stage.
- Converts an asynchronous 8N1 serial line into 8-bit ASCII characters, one per frame, with a one-cycle valid strobe.
- The recognizer advances its state only on cycles where char_valid is high.
- Also flags framing errors so the top level can force the recognizer into its fail path.

Parameters:
- CLKS_PER_BIT, 16, clk cycles per serial bit; even, >= 4.
- HALF_BIT, CLKS_PER_BIT/2, derived; offset from start-bit detection to the start-bit sample point.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset (reset==0 clears all state immediately, independent of clk).
- rxd  input  1  serial line; idles high; asynchronous to clk.
- char  output  8  last correctly received character; holds between frames.
- char_valid  output  1  one-cycle pulse: char was updated this cycle.
- frame_err  output  1  one-cycle pulse: stop bit sampled low.
- busy  output  1  high in every state except IDLE.

Behaviour:
- Synchronizer:
  - rxd passes through a 2-flop synchronizer; both flops reset to 1.
  - The FSM uses only the synchronized signal rx_s.
- Reset values: char=8'h00, char_valid=0, frame_err=0, busy=0, state=IDLE, bit counter=0, cycle counter=0, shift register=0.
- FSM states: IDLE, START, DATA, STOP, WAIT_HIGH (3-bit encoding; unused codes go to IDLE).
- Timing reference: t=0 is the cycle in which the FSM is in IDLE and first sees rx_s=0.
- IDLE:
  - rx_s=0 -> START, cycle counter cleared.
  - Otherwise stay in IDLE.
- START:
  - At t=HALF_BIT, sample rx_s.
  - 0 -> DATA (counter cleared, bit index 0).
  - 1 -> glitch; return to IDLE with no output pulse.
- DATA:
  - Data samples at t = HALF_BIT + k*CLKS_PER_BIT, k=1..8.
  - Samples shift in LSB first (first data bit lands in char[0]).
  - After the 8th sample -> STOP.
- STOP:
  - Stop-bit sample at t = HALF_BIT + 9*CLKS_PER_BIT.
  - rx_s=1: on the next cycle char <= shift register, char_valid=1 for exactly one cycle; state -> IDLE.
  - rx_s=0: on the next cycle frame_err=1 for one cycle; char unchanged; char_valid stays 0; state -> WAIT_HIGH.
- WAIT_HIGH:
  - Stay until rx_s=1, then go to IDLE.
  - Prevents a break or stuck-low line from producing repeated frames.
- Back-to-back frames: a start bit may begin in the cycle after the stop sample. IDLE is re-entered in time, so there is no lost character at full line rate.
- char_valid and frame_err are never high in the same cycle.
- busy is high from the cycle after t=0 until the cycle the FSM re-enters IDLE.
- Reset mid-frame: reset low at any point aborts the frame immediately.
  - All outputs return to reset values; no pulse is emitted.
  - After release, the receiver waits in IDLE for a fresh falling edge.
  - A line already low at release is treated as a start bit only after the synchronizer sees it (rx_s reset value is 1).
- Counters:
  - Cycle counter width is clog2(CLKS_PER_BIT); bit index is 4 bits.
  - The cycle counter clears at every sample point; no wrap beyond CLKS_PER_BIT-1.

Test Plan:
- CLKS_PER_BIT=4, send 0x37 ('7') with a valid stop bit -> char=8'h37, char_valid high exactly 1 cycle, at t=2+36+1; frame_err stays 0.
- Send "1","+","2","=","3" back-to-back with no idle gaps -> five char_valid pulses, char sequence 31,2B,32,3D,33, spaced 40 cycles apart.
- Drive rxd low for 1 cycle (shorter than HALF_BIT), then high -> no char_valid, busy returns to 0, char unchanged.
- Send 0x41 with stop bit 0, then hold rxd low for 100 cycles -> one frame_err pulse, no char_valid, char keeps its previous value, busy high until rxd returns high.
- Assert reset low during data bit 4 of 0x55, release, then send 0x2D -> no output for the aborted frame; after release char=00; then char=8'h2D with one char_valid.
- Hold rxd high for 1000 cycles after reset -> busy, char_valid and frame_err all stay 0.
